// File: rtl/uart_ring_buffer.sv
// -----------------------------------------------------------------------------
// uart_ring_buffer
//
// Byte-wide FIFO ring buffer that sits between the UART receive path and the
// consuming logic. The producer may offer one word per clock. The consumer pulls
// words in arrival order with a one-cycle request/acknowledge handshake.
// A full buffer drops new words unless a read frees a slot in the same cycle.
// An empty buffer refuses reads.
//
// Parameters
//   DATA_WIDTH  width of each stored word and of the data ports (default 8)
//   DEPTH       number of storage entries, power of two, >= 2 (default 16)
//
// Ports
//   clk          in   single clock; all state changes on its rising edge
//   reset        in   asynchronous, active-low reset
//   writeEnable  in   offers dataWrite for storage at the rising edge
//   dataWrite    in   word to store
//   readRequest  in   requests the oldest stored word at the rising edge
//   dataReadAck  out  registered; high for one cycle when dataRead is a fresh pop
//   dataRead     out  registered; last popped word
// -----------------------------------------------------------------------------
module uart_ring_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic [DATA_WIDTH-1:0] dataWrite,
  input  logic                  readRequest,
  output logic                  dataReadAck,
  output logic [DATA_WIDTH-1:0] dataRead
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra MSB so that equal low bits can be told apart as
  // either empty (MSBs equal) or full (MSBs differ).
  logic [ADDR_W:0]         wr_ptr_r;
  logic [ADDR_W:0]         rd_ptr_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
  logic                    data_read_ack_r;
  logic [DATA_WIDTH-1:0]   data_read_r;

  logic                    empty_s;
  logic                    full_s;
  logic                    rd_fire_s;
  logic                    wr_fire_s;
  logic [ADDR_W-1:0]       wr_idx_s;
  logic [ADDR_W-1:0]       rd_idx_s;

  // Occupancy decode and read/write qualification.
  always_comb begin
    empty_s   = 1'b0;
    full_s    = 1'b0;
    rd_fire_s = 1'b0;
    wr_fire_s = 1'b0;
    wr_idx_s  = wr_ptr_r[ADDR_W-1:0];
    rd_idx_s  = rd_ptr_r[ADDR_W-1:0];

    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]) &&
              (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]);

    // A read on an empty buffer is refused; there is no write-through bypass.
    if (readRequest && !empty_s) begin
      rd_fire_s = 1'b1;
    end else begin
      rd_fire_s = 1'b0;
    end

    // When full, a write only lands if a read frees the oldest slot this cycle.
    if (writeEnable) begin
      if (!full_s) begin
        wr_fire_s = 1'b1;
      end else begin
        wr_fire_s = rd_fire_s;
      end
    end else begin
      wr_fire_s = 1'b0;
    end
  end

  // Write and read pointer update; reset discards all stored words at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {(ADDR_W+1){1'b0}};
      rd_ptr_r <= {(ADDR_W+1){1'b0}};
    end else begin
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
      end
      if (rd_fire_s) begin
        rd_ptr_r <= rd_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array; not cleared by reset, writes blocked while reset is low.
  // On a full-and-read cycle the write lands on the slot being popped; the
  // output register captures the old contents since both update at the edge.
  always_ff @(posedge clk) begin
    if (reset && wr_fire_s) begin
      mem_r[wr_idx_s] <= dataWrite;
    end
  end

  // Registered read port: ack pulses for exactly one cycle per popped word,
  // data holds the last popped word otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_read_ack_r <= 1'b0;
      data_read_r     <= {DATA_WIDTH{1'b0}};
    end else begin
      if (rd_fire_s) begin
        data_read_ack_r <= 1'b1;
        data_read_r     <= mem_r[rd_idx_s];
      end else begin
        data_read_ack_r <= 1'b0;
      end
    end
  end

  assign dataReadAck = data_read_ack_r;
  assign dataRead    = data_read_r;

endmodule

// File: tb/tb_uart_ring_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_ring_buffer
//
// Self-checking bench for uart_ring_buffer. A queue model of the FIFO decides
// each cycle whether the read and the write are accepted. Popped bytes are
// pushed to a scoreboard queue and compared against dataRead when the DUT acks.
// -----------------------------------------------------------------------------
module tb_uart_ring_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          writeEnable;
  logic [DW-1:0] dataWrite;
  logic          readRequest;
  logic          dataReadAck;
  logic [DW-1:0] dataRead;

  int compared;
  int mismatched;

  logic [DW-1:0] model_q[$];   // contents the FIFO should hold
  logic [DW-1:0] exp_q[$];     // scoreboard: popped bytes awaiting comparison
  logic [DW-1:0] last_data;    // value dataRead should be holding
  int            ack_seen;

  uart_ring_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEnable),
    .dataWrite   (dataWrite),
    .readRequest (readRequest),
    .dataReadAck (dataReadAck),
    .dataRead    (dataRead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared = compared + 1;
    if (obs !== exp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, predict, check #1 after the rising edge.
  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic rr);
    logic rd_ok;
    logic wr_ok;
    logic [DW-1:0] e;
    @(negedge clk);
    writeEnable = we;
    dataWrite   = wd;
    readRequest = rr;
    rd_ok = rr && (model_q.size() > 0);
    wr_ok = we && ((model_q.size() < DEPTH) || rd_ok);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(wd);
    @(posedge clk);
    #1;
    chk("ack", {31'd0, dataReadAck}, {31'd0, rd_ok});
    if (dataReadAck) begin
      ack_seen = ack_seen + 1;
      if (exp_q.size() == 0) begin
        chk("spurious_ack", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("data", {24'd0, dataRead}, {24'd0, e});
        last_data = e;
      end
    end else begin
      chk("hold", {24'd0, dataRead}, {24'd0, last_data});
    end
  endtask

  initial begin
    logic [DW-1:0] seq [6];
    logic [DW-1:0] v;
    compared    = 0;
    mismatched  = 0;
    last_data   = 8'h00;
    ack_seen    = 0;
    reset       = 1'b0;
    writeEnable = 1'b0;
    dataWrite   = 8'h00;
    readRequest = 1'b0;
    seq[0] = 8'h12; seq[1] = 8'h23; seq[2] = 8'h34;
    seq[3] = 8'h45; seq[4] = 8'h56; seq[5] = 8'h78;

    // Reset state, with inputs active to show they are ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    writeEnable = 1'b1;
    readRequest = 1'b1;
    dataWrite   = 8'hEE;
    @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, dataReadAck}, 32'd0);
    chk("rst_data", {24'd0, dataRead}, 32'd0);
    @(negedge clk);
    writeEnable = 1'b0;
    readRequest = 1'b0;
    reset       = 1'b1;

    // Six writes with no reads: outputs stay quiet.
    for (int i = 0; i < 6; i++) cycle(1'b1, seq[i], 1'b0);
    // Seven consecutive requests: six pops then an empty cycle holding 0x78.
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("hold_78", {24'd0, dataRead}, 32'h78);

    // Overflow: 20 writes, only the first 16 survive.
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i), 1'b0);
    ack_seen = 0;
    for (int i = 0; i < 18; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("ovf_acks", ack_seen, 32'd16);
    chk("ovf_last", {24'd0, dataRead}, 32'h0F);

    // Read on empty with simultaneous write: no ack, then the byte comes out.
    cycle(1'b1, 8'hA5, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("bypass_a5", {24'd0, dataRead}, 32'hA5);

    // Full buffer with simultaneous read and write keeps occupancy at DEPTH.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    cycle(1'b1, 8'hC0, 1'b1);
    cycle(1'b1, 8'hC1, 1'b0);          // dropped: still full
    ack_seen = 0;
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("full_rw_acks", ack_seen, DEPTH);

    // Wrap-around at half occupancy: 40 cycles of read+write.
    for (int i = 0; i < DEPTH / 2; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h88 + i), 1'b1);
    for (int i = 0; i < DEPTH / 2 + 1; i++) cycle(1'b0, 8'h00, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      v = 8'($urandom);
      cycle(1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1);

    // Mid-operation asynchronous reset.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);          // dataRead becomes 0xD0
    @(negedge clk);
    readRequest = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_data", {24'd0, dataRead}, 32'd0);
    chk("async_rst_ack", {31'd0, dataReadAck}, 32'd0);
    model_q.delete();
    exp_q.delete();
    last_data = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, 8'h00, 1'b1);          // empty after reset: no ack
    chk("post_rst_data", {24'd0, dataRead}, 32'd0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_ring_buffer.md
# uart_ring_buffer

Byte-wide FIFO ring buffer between the UART receive path and the consuming logic. The producer writes one byte per clock. The consumer pulls bytes in arrival order with a one-cycle request/acknowledge handshake. A full buffer drops new bytes; an empty buffer refuses reads.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word and of the data ports.
- DEPTH, 16, number of storage entries; must be a power of two, ≥ 2.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- writeEnable  input  1  when high at a rising edge, dataWrite is offered for storage.
- dataWrite  input  DATA_WIDTH  byte to store.
- readRequest  input  1  when high at a rising edge, requests the oldest stored byte.
- dataReadAck  output  1  registered; high for one cycle when dataRead carries a newly popped byte.
- dataRead  output  DATA_WIDTH  registered; last popped byte.

## Operation
- Storage is a DEPTH-entry array addressed by a write pointer and a read pointer.
  - Each pointer is log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - Pointers increment modulo 2·DEPTH; the array is indexed by the low log2(DEPTH) bits, so wrap-around is seamless.
- empty = (wrPtr == rdPtr).
- full = (low bits equal) and (MSBs differ).
- Write:
  - If writeEnable=1 and not full, store dataWrite at mem[wrPtr] and increment wrPtr.
  - If full, the write is accepted only if a read is also performed in the same cycle.
  - Otherwise the byte is silently dropped; stored contents and pointers are unchanged.
- Read:
  - If readRequest=1 and not empty, set dataRead <= mem[rdPtr], dataReadAck <= 1, and increment rdPtr.
  - If readRequest=1 and empty, set dataReadAck <= 0; dataRead holds its previous value.
  - If readRequest=0, set dataReadAck <= 0; dataRead holds.
- Simultaneous read and write:
  - Empty buffer: the read sees empty (no ack, no bypass); the write is stored.
  - Full buffer: both complete; the occupancy stays DEPTH.
  - Otherwise: both complete independently.
- Bytes are returned strictly in write order; none is duplicated.
- Reset (reset=0, asynchronous assert, synchronous-to-clk deassert in use):
  - wrPtr=0, rdPtr=0, dataReadAck=0, dataRead=0.
  - Memory contents are not cleared.
  - Asserting reset mid-operation discards all stored bytes immediately.
  - While reset is low, writes and reads are ignored.

## Timing
- Write latency: a byte written at edge N is readable by a request sampled at edge N+1 or later.
- Read latency: a request sampled at edge N produces dataRead/dataReadAck valid after edge N; dataReadAck is high for exactly cycle N→N+1.
- readRequest held high for consecutive cycles pops one byte per cycle until empty; dataReadAck then drops low on the first empty cycle.
- Throughput: one write and one read per cycle, sustained.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then write 0x12, 0x23, 0x34, 0x45, 0x56, 0x78 on consecutive cycles with readRequest=0 -> dataReadAck stays 0 and dataRead stays 0x00 throughout.
- After the previous step, hold readRequest=1 for 7 cycles -> dataRead = 0x12, 0x23, 0x34, 0x45, 0x56, 0x78 with dataReadAck=1 on the first six cycles, then dataReadAck=0 with dataRead holding 0x78.
- With DEPTH=16, write 0x00..0x13 (20 bytes), then read continuously -> exactly 16 acks with 0x00..0x0F; 0x10..0x13 are lost.
- Read request on an empty buffer, with a simultaneous write of 0xA5 -> first cycle dataReadAck=0; next request returns 0xA5 with ack.
- Wrap-around: 40 cycles of simultaneous write (incrementing values) and read at half occupancy -> the output sequence equals the input sequence with no gaps or repeats.
- Write 5 bytes, assert reset mid-cycle asynchronously, release, then request -> outputs go to 0 immediately on reset; the post-reset request gets dataReadAck=0 (empty).
